// File: rtl/worley_pkg.sv
// rtl/worley_pkg.sv - shared types, reset values and saturation helper for the Worley noise pipe
package worley_pkg;

  localparam int NUM_POINTS = 4;
  localparam int IDX_W      = $clog2(NUM_POINTS);

  // Generous field widths so one struct serves every coordinate/velocity configuration.
  typedef struct packed {
    logic [15:0]        x;
    logic [15:0]        y;
    logic signed [7:0]  vx;
    logic signed [7:0]  vy;
  } point_t;

  function automatic point_t reset_point(input int i, input int h_active, input int v_active);
    point_t p;
    p.x  = 16'((64 + 128 * i) % h_active);
    p.y  = 16'((48 + 96 * i) % v_active);
    p.vx = 8'sd1;
    p.vy = ((i % 2) == 0) ? 8'sd1 : -8'sd1;
    return p;
  endfunction

  function automatic logic [63:0] sat_dist(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/worley_noise_pipe_if.sv
// rtl/worley_noise_pipe_if.sv - pixel, config and noise signals of the Worley noise pipe
interface worley_noise_pipe_if #(
  parameter int NUM_POINTS = 4,
  parameter int COORD_W    = 10,
  parameter int VEL_W      = 4,
  parameter int OUT_W      = 8
);
  localparam int IDX_W = $clog2(NUM_POINTS);

  logic                      pix_valid;
  logic [COORD_W-1:0]        pix_x;
  logic [COORD_W-1:0]        pix_y;
  logic                      frame_tick;
  logic                      cfg_we;
  logic [IDX_W-1:0]          cfg_idx;
  logic [COORD_W-1:0]        cfg_x;
  logic [COORD_W-1:0]        cfg_y;
  logic signed [VEL_W-1:0]   cfg_vx;
  logic signed [VEL_W-1:0]   cfg_vy;
  logic                      noise_valid;
  logic [OUT_W-1:0]          noise;
  logic [IDX_W-1:0]          nearest_idx;

  modport master (
    output pix_valid, pix_x, pix_y, frame_tick,
    output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_vx, cfg_vy,
    input  noise_valid, noise, nearest_idx
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, frame_tick,
    input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_vx, cfg_vy,
    output noise_valid, noise, nearest_idx
  );
endinterface

// File: rtl/worley_point_mover.sv
// rtl/worley_point_mover.sv - one feature point: position/velocity state, edge bounce, config overwrite
module worley_point_mover
  import worley_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int VEL_W     = 4,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int POINT_IDX = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_frame_tick,
  input  logic                    i_cfg_we,
  input  logic [COORD_W-1:0]      i_cfg_x,
  input  logic [COORD_W-1:0]      i_cfg_y,
  input  logic signed [VEL_W-1:0] i_cfg_vx,
  input  logic signed [VEL_W-1:0] i_cfg_vy,
  output logic [COORD_W-1:0]      o_x,
  output logic [COORD_W-1:0]      o_y
);

  localparam point_t RST = reset_point(POINT_IDX, H_ACTIVE, V_ACTIVE);

  logic [COORD_W-1:0]       r_x;
  logic [COORD_W-1:0]       r_y;
  logic signed [VEL_W-1:0]  r_vx;
  logic signed [VEL_W-1:0]  r_vy;
  logic [VEL_W+COORD_W-1:0] w_step_x;
  logic [VEL_W+COORD_W-1:0] w_step_y;

  // Returns {velocity, position} after one step, mirrored back inside 0..lim-1.
  function automatic logic [VEL_W+COORD_W-1:0] bounce(
    input logic [COORD_W-1:0]      p,
    input logic signed [VEL_W-1:0] v,
    input int                      lim
  );
    int   nx;
    int   np;
    logic flip;
    nx   = int'(p) + int'(v);
    flip = 1'b1;
    if (nx < 0) begin
      np = -nx;
    end else if (nx > lim - 1) begin
      np = 2 * (lim - 1) - nx;
    end else begin
      np   = nx;
      flip = 1'b0;
    end
    if (np < 0) begin
      np = 0;
    end else if (np > lim - 1) begin
      np = lim - 1;
    end
    return {(flip ? -v : v), COORD_W'(np)};
  endfunction

  assign w_step_x = bounce(r_x, r_vx, H_ACTIVE);
  assign w_step_y = bounce(r_y, r_vy, V_ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x  <= COORD_W'(RST.x);
      r_y  <= COORD_W'(RST.y);
      r_vx <= VEL_W'(RST.vx);
      r_vy <= VEL_W'(RST.vy);
    end else if (i_cfg_we) begin
      r_x  <= (int'(i_cfg_x) > H_ACTIVE - 1) ? COORD_W'(H_ACTIVE - 1) : i_cfg_x;
      r_y  <= (int'(i_cfg_y) > V_ACTIVE - 1) ? COORD_W'(V_ACTIVE - 1) : i_cfg_y;
      r_vx <= i_cfg_vx;
      r_vy <= i_cfg_vy;
    end else if (i_frame_tick) begin
      r_x  <= w_step_x[COORD_W-1:0];
      r_y  <= w_step_y[COORD_W-1:0];
      r_vx <= w_step_x[VEL_W+COORD_W-1:COORD_W];
      r_vy <= w_step_y[VEL_W+COORD_W-1:COORD_W];
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;

endmodule

// File: rtl/worley_noise_pipe.sv
// rtl/worley_noise_pipe.sv - pipelined Worley noise: distance stage, min tree, noise output
// Define WORLEY_F2_EN to also track the second-nearest distance and output F2-F1.
module worley_noise_pipe
  import worley_pkg::*;
#(
  parameter int NUM_POINTS = 4,
  parameter int COORD_W    = 10,
  parameter int DIST_W     = 16,
  parameter int OUT_W      = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int VEL_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  worley_noise_pipe_if.slave bus
);

  localparam int LVLS  = $clog2(NUM_POINTS);
  localparam int NODES = 2 * NUM_POINTS - 1;
  localparam int SQ_W  = 2 * COORD_W + 1;

  logic [COORD_W-1:0] w_px [NUM_POINTS];
  logic [COORD_W-1:0] w_py [NUM_POINTS];

  for (genvar i = 0; i < NUM_POINTS; i++) begin : g_pt
    worley_point_mover #(
      .COORD_W  (COORD_W),
      .VEL_W    (VEL_W),
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .POINT_IDX(i)
    ) u_mover (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_frame_tick(bus.frame_tick),
      .i_cfg_we    (bus.cfg_we && (bus.cfg_idx == LVLS'(i))),
      .i_cfg_x     (bus.cfg_x),
      .i_cfg_y     (bus.cfg_y),
      .i_cfg_vx    (bus.cfg_vx),
      .i_cfg_vy    (bus.cfg_vy),
      .o_x         (w_px[i]),
      .o_y         (w_py[i])
    );
  end

  logic               r_s1_vld;
  logic [LVLS:0]      r_lvl_vld;
  logic [COORD_W-1:0] r_s1_dx [NUM_POINTS];
  logic [COORD_W-1:0] r_s1_dy [NUM_POINTS];
  logic [SQ_W-1:0]    w_sq    [NUM_POINTS];
  logic [DIST_W-1:0]  w_leaf_d [NUM_POINTS];

  // Heap-ordered tree: node k has children 2k+1 / 2k+2, leaves NUM_POINTS-1.. hold points 0..N-1,
  // so the left child always covers lower indices and wins ties.
  logic [DIST_W-1:0]  r_node_d1  [NODES];
  logic [LVLS-1:0]    r_node_idx [NODES];
  logic [DIST_W-1:0]  w_win_d1   [NUM_POINTS-1];
  logic [LVLS-1:0]    w_win_idx  [NUM_POINTS-1];
`ifdef WORLEY_F2_EN
  logic [DIST_W-1:0]  r_node_d2  [NODES];
  logic [DIST_W-1:0]  w_win_d2   [NUM_POINTS-1];
`endif

  logic               r_noise_valid;
  logic [OUT_W-1:0]   r_noise;
  logic [LVLS-1:0]    r_nearest_idx;
  logic [DIST_W-1:0]  w_metric;
  logic [OUT_W-1:0]   w_noise;

  always_comb begin
    for (int i = 0; i < NUM_POINTS; i++) begin
      w_sq[i]     = SQ_W'(r_s1_dx[i]) * SQ_W'(r_s1_dx[i]) + SQ_W'(r_s1_dy[i]) * SQ_W'(r_s1_dy[i]);
      w_leaf_d[i] = DIST_W'(sat_dist(64'(w_sq[i]), DIST_W));
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_POINTS - 1; k++) begin
      if (r_node_d1[2*k+1] <= r_node_d1[2*k+2]) begin
        w_win_d1[k]  = r_node_d1[2*k+1];
        w_win_idx[k] = r_node_idx[2*k+1];
`ifdef WORLEY_F2_EN
        w_win_d2[k]  = (r_node_d2[2*k+1] <= r_node_d1[2*k+2]) ? r_node_d2[2*k+1] : r_node_d1[2*k+2];
`endif
      end else begin
        w_win_d1[k]  = r_node_d1[2*k+2];
        w_win_idx[k] = r_node_idx[2*k+2];
`ifdef WORLEY_F2_EN
        w_win_d2[k]  = (r_node_d2[2*k+2] <= r_node_d1[2*k+1]) ? r_node_d2[2*k+2] : r_node_d1[2*k+1];
`endif
      end
    end
  end

  // Datapath registers carry no reset; only the valid chain qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_POINTS; i++) begin
      r_s1_dx[i] <= (bus.pix_x >= w_px[i]) ? bus.pix_x - w_px[i] : w_px[i] - bus.pix_x;
      r_s1_dy[i] <= (bus.pix_y >= w_py[i]) ? bus.pix_y - w_py[i] : w_py[i] - bus.pix_y;
      r_node_d1[NUM_POINTS-1+i]  <= w_leaf_d[i];
      r_node_idx[NUM_POINTS-1+i] <= LVLS'(i);
`ifdef WORLEY_F2_EN
      r_node_d2[NUM_POINTS-1+i]  <= '1;
`endif
    end
    for (int k = 0; k < NUM_POINTS - 1; k++) begin
      r_node_d1[k]  <= w_win_d1[k];
      r_node_idx[k] <= w_win_idx[k];
`ifdef WORLEY_F2_EN
      r_node_d2[k]  <= w_win_d2[k];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_lvl_vld <= '0;
    end else begin
      r_s1_vld  <= bus.pix_valid;
      r_lvl_vld <= {r_s1_vld, r_lvl_vld[LVLS:1]};
    end
  end

`ifdef WORLEY_F2_EN
  assign w_metric = r_node_d2[0] - r_node_d1[0];
`else
  assign w_metric = r_node_d1[0];
`endif
  assign w_noise = ~OUT_W'(w_metric >> (DIST_W - OUT_W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_noise_valid <= 1'b0;
      r_noise       <= '0;
      r_nearest_idx <= '0;
    end else begin
      r_noise_valid <= r_lvl_vld[0];
      if (r_lvl_vld[0]) begin
        r_noise       <= w_noise;
        r_nearest_idx <= r_node_idx[0];
      end
    end
  end

  assign bus.noise_valid = r_noise_valid;
  assign bus.noise       = r_noise;
  assign bus.nearest_idx = r_nearest_idx;

endmodule

// File: tb/tb_worley_noise_pipe.sv
// tb/tb_worley_noise_pipe.sv - directed self-checking bench for worley_noise_pipe
module tb_worley_noise_pipe;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  worley_noise_pipe_if #(.NUM_POINTS(4), .COORD_W(10), .VEL_W(4), .OUT_W(8)) bus ();

  worley_noise_pipe #(
    .NUM_POINTS(4), .COORD_W(10), .DIST_W(16), .OUT_W(8),
    .H_ACTIVE(640), .V_ACTIVE(480), .VEL_W(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.frame_tick = 1'b0;
    bus.cfg_we     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic cfg_pt(input int idx, input int x, input int y, input int vx, input int vy);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = 2'(idx);
    bus.cfg_x   = 10'(x);
    bus.cfg_y   = 10'(y);
    bus.cfg_vx  = 4'(vx);
    bus.cfg_vy  = 4'(vy);
    step();
    bus.cfg_we  = 1'b0;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  // One pixel in; valid must be low after 4 edges and high after exactly 5.
  task automatic probe(input string tag, input int x, input int y, input int exp_noise, input int exp_idx);
    bus.pix_valid = 1'b1;
    bus.pix_x     = 10'(x);
    bus.pix_y     = 10'(y);
    step();
    bus.pix_valid = 1'b0;
    repeat (3) step();
    check({tag, "_early"}, 32'(bus.noise_valid), 32'd0);
    step();
    check({tag, "_vld"}, 32'(bus.noise_valid), 32'd1);
    check({tag, "_noise"}, 32'(bus.noise), 32'(exp_noise));
    check({tag, "_idx"}, 32'(bus.nearest_idx), 32'(exp_idx));
  endtask

  initial begin
    logic [15:0] pat;
    int          e;
    logic        expv;
    n_checks = 0;
    n_errors = 0;
    bus.pix_x = '0;
    bus.pix_y = '0;
    bus.cfg_idx = '0;
    bus.cfg_x = '0;
    bus.cfg_y = '0;
    bus.cfg_vx = '0;
    bus.cfg_vy = '0;

    do_reset();
    check("rst_vld", 32'(bus.noise_valid), 32'd0);
    check("rst_noise", 32'(bus.noise), 32'd0);
    check("rst_idx", 32'(bus.nearest_idx), 32'd0);

    probe("p0_exact", 64, 48, 8'hFF, 0);
    step();
    check("hold_noise", 32'(bus.noise), 32'hFF);

    cfg_pt(1, 300, 200, 0, 0);
    probe("p1_d25", 303, 204, 8'hFF, 1);
    probe("sat", 0, 479, 8'h00, 0);

    // Right-edge bounce: 639+3 reflects to 636, then 633.
    do_reset();
    cfg_pt(0, 639, 48, 3, 0);
    tick();
    probe("bx_a", 652, 48, 8'hFE, 0);
    probe("bx_b", 652, 63, 8'hFE, 0);
    tick();
    probe("bx2_a", 649, 48, 8'hFE, 0);
    probe("bx2_b", 649, 63, 8'hFE, 0);

    // Left-edge bounce: 1-2 reflects to 1 with v=+2, then 3.
    do_reset();
    cfg_pt(1, 1, 200, -2, 0);
    tick();
    probe("bl_a", 17, 200, 8'hFE, 1);
    probe("bl_b", 17, 215, 8'hFE, 1);
    tick();
    probe("bl2_a", 19, 200, 8'hFE, 1);
    probe("bl2_b", 19, 215, 8'hFE, 1);

    // Bubbled stream with a frame tick in cycle 6: earlier pixels see x=100 (d=256), later x=107 (d=81).
    do_reset();
    cfg_pt(0, 100, 100, 7, 0);
    pat = 16'b1011_0110_1101_0111;
    for (int c = 0; c < 22; c++) begin
      bus.pix_valid  = (c < 16) ? pat[c] : 1'b0;
      bus.pix_x      = 10'd116;
      bus.pix_y      = 10'd100;
      bus.frame_tick = (c == 6);
      step();
      e    = c - 4;
      expv = (e >= 0 && e < 16) ? pat[e] : 1'b0;
      check($sformatf("strm_vld%0d", c), 32'(bus.noise_valid), 32'(expv));
      if (expv) begin
        check($sformatf("strm_noise%0d", c), 32'(bus.noise), (e <= 6) ? 32'hFE : 32'hFF);
      end
    end
    bus.frame_tick = 1'b0;

    // Config write and frame tick together: point 2 takes cfg, point 0 steps to (65,49).
    do_reset();
    bus.frame_tick = 1'b1;
    cfg_pt(2, 500, 400, 5, 0);
    bus.frame_tick = 1'b0;
    probe("cw_p2a", 516, 400, 8'hFE, 2);
    probe("cw_p2b", 516, 415, 8'hFE, 2);
    probe("cw_p0a", 81, 49, 8'hFE, 0);
    probe("cw_p0b", 81, 64, 8'hFE, 0);

    // Reset in the middle of a stream drops in-flight pixels.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      bus.pix_valid = (c < 3);
      bus.pix_x     = 10'd64;
      bus.pix_y     = 10'd48;
      rst_n         = (c != 3);
      step();
      if (c >= 3) check($sformatf("mrst_vld%0d", c), 32'(bus.noise_valid), 32'd0);
    end
    rst_n = 1'b1;
    probe("mrst_new", 64, 48, 8'hFF, 0);

    // Two points equidistant (d=400) from the pixel.
    do_reset();
    cfg_pt(0, 200, 200, 0, 0);
    cfg_pt(1, 240, 200, 0, 0);
`ifdef WORLEY_F2_EN
    probe("equi", 220, 200, 8'hFF, 0);
`else
    probe("equi", 220, 200, 8'hFE, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
